// File: rtl/sc_stream_decoder_if.sv
// Job/stream/result bundle for the stochastic-to-binary decoder.
interface sc_stream_decoder_if #(
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 6,
  parameter int OUT_WIDTH   = 32
);
  logic                   start;
  logic [SHIFT_WIDTH-1:0] shift_in;
  logic                   bit_in;
  logic                   bit_valid;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   result;
  logic [CNT_WIDTH-1:0]   ones_cnt;

  // Producer of jobs and stream bits, consumer of results.
  modport master (
    output start, shift_in, bit_in, bit_valid, out_ready,
    input  busy, out_valid, result, ones_cnt
  );

  // The decoder itself.
  modport slave (
    input  start, shift_in, bit_in, bit_valid, out_ready,
    output busy, out_valid, result, ones_cnt
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic stream decoder: counts 1s over a STREAM_LENGTH-bit unipolar
// stream, then left-shifts the count by the exponent latched with the job.
module sc_stream_decoder #(
  parameter int STREAM_LENGTH = 32,
  parameter int CNT_WIDTH     = 6,
  parameter int SHIFT_WIDTH   = 6,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  sc_stream_decoder_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [CNT_WIDTH-1:0]   r_len;
  logic [CNT_WIDTH-1:0]   r_ones;
  logic [CNT_WIDTH-1:0]   r_ones_cnt;
  logic [OUT_WIDTH-1:0]   r_result;

  logic                   w_take_bit;
  logic                   w_last_bit;
  logic                   w_accept;
  logic [CNT_WIDTH-1:0]   w_ones_nxt;
  logic [OUT_WIDTH-1:0]   w_denorm;

  // Bits only count in ACCUM; the bit moving len to STREAM_LENGTH closes the stream.
  assign w_take_bit = (r_state == S_ACCUM) && bus.bit_valid;
  assign w_last_bit = w_take_bit && (r_len == CNT_WIDTH'(STREAM_LENGTH - 1));
  // A job is accepted from IDLE, or on the result handshake cycle for zero-bubble chaining.
  assign w_accept   = bus.start && ((r_state == S_IDLE) ||
                                    ((r_state == S_HOLD) && bus.out_ready));
  assign w_ones_nxt = r_ones + CNT_WIDTH'(bus.bit_in);

  // De-normalise the final count; shifts past the result width flush to zero.
  always_comb begin
    w_denorm = '0;
    if (32'(r_shift) < OUT_WIDTH)
      w_denorm = OUT_WIDTH'(w_ones_nxt) << r_shift;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)     w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last_bit)    w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_state_nxt = bus.start ? S_ACCUM : S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Job counters and result registers; result persists until the next stream closes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_len      <= '0;
      r_ones     <= '0;
      r_ones_cnt <= '0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= bus.shift_in;
        r_len   <= '0;
        r_ones  <= '0;
      end else if (w_take_bit) begin
        r_len  <= r_len + CNT_WIDTH'(1);
        r_ones <= w_ones_nxt;
      end
      if (w_last_bit) begin
        r_ones_cnt <= w_ones_nxt;
        r_result   <= w_denorm;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.result    = r_result;
  assign bus.ones_cnt  = r_ones_cnt;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed + randomized bench for sc_stream_decoder with a count/shift reference model.
module tb_sc_stream_decoder;
  localparam int SL = 32;
  localparam int CW = 6;
  localparam int SW = 6;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_stream_decoder_if #(.SHIFT_WIDTH(SW), .CNT_WIDTH(CW), .OUT_WIDTH(OW)) bus();

  sc_stream_decoder #(
    .STREAM_LENGTH(SL), .CNT_WIDTH(CW), .SHIFT_WIDTH(SW), .OUT_WIDTH(OW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit sbits [SL];
  int cur_sh;
  logic [63:0] exp_res;
  logic [63:0] exp_ones;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: popcount of the stream, scaled by 2**shift, reduced modulo 2**OW.
  function automatic int ref_ones();
    int s = 0;
    for (int i = 0; i < SL; i++) s += int'(sbits[i]);
    return s;
  endfunction

  function automatic logic [63:0] ref_result(input int ones, input int sh);
    longint p;
    if (sh >= OW) return 64'd0;
    p = longint'(ones) * (longint'(1) << sh);
    return 64'(p % (longint'(1) << OW));
  endfunction

  task automatic start_job(input int sh);
    bus.start    = 1'b1;
    bus.shift_in = SW'(sh);
    cur_sh       = sh;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Feed n stream bits; optional fixed stall every 'every' cycles and random stalls.
  task automatic feed(input int n, input int every, input int stall_pct, input bit rand_start);
    int cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (every != 0 && (cyc % every) == every - 1) begin
        bus.bit_valid = 1'b0; bus.bit_in = 1'b1; tick(); cyc++;
      end
      for (int s = 0; s < 4 && int'($urandom_range(99)) < stall_pct; s++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'($urandom);
        bus.start     = rand_start & 1'($urandom);
        bus.shift_in  = SW'($urandom);
        tick();
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = sbits[i];
      bus.start     = rand_start & 1'($urandom);
      bus.shift_in  = SW'($urandom);
      tick(); cyc++;
      if (i == SL - 2) check("no_early_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    exp_ones = 64'(ref_ones());
    exp_res  = ref_result(ref_ones(), cur_sh);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_result"},    64'(bus.result),    exp_res);
    check({tag, "_ones_cnt"},  64'(bus.ones_cnt),  exp_ones);
  endtask

  // Backpressure with stray stream bits that must be ignored.
  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      bus.out_ready = 1'b0;
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
      check("hold_valid",  64'(bus.out_valid), 64'd1);
      check("hold_result", 64'(bus.result),    exp_res);
      check("hold_ones",   64'(bus.ones_cnt),  exp_ones);
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic release_job(input bit chain, input int nsh);
    bus.out_ready = 1'b1;
    bus.start     = chain;
    bus.shift_in  = SW'(nsh);
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("rel_valid_low", 64'(bus.out_valid), 64'd0);
    check("rel_busy",      64'(bus.busy),      64'(chain));
    check("rel_result_kept", 64'(bus.result),  exp_res);
    if (chain) cur_sh = nsh;
  endtask

  initial begin
    bit chained;
    int nsh;
    int dens;

    bus.start = 1'b0; bus.shift_in = '0; bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_ones_cnt",  64'(bus.ones_cnt),  64'd0);
    rst = 1'b0;

    // Bits in IDLE are ignored
    bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick(); tick(); tick();
    bus.bit_valid = 1'b0;
    check("idle_busy", 64'(bus.busy), 64'd0);

    // 1: all ones, shift 0
    for (int i = 0; i < SL; i++) sbits[i] = 1'b1;
    start_job(0);
    feed(SL, 0, 0, 1'b0);
    expect_done("t1");
    check("t1_literal", 64'(bus.result), 64'd32);
    release_job(1'b0, 0);

    // 2: alternating, shift 3, stall every 3rd cycle
    for (int i = 0; i < SL; i++) sbits[i] = ((i % 2) == 0);
    start_job(3);
    feed(SL, 3, 0, 1'b0);
    expect_done("t2");
    check("t2_literal", 64'(bus.result), 64'd128);
    check("t2_ones_lit", 64'(bus.ones_cnt), 64'd16);
    release_job(1'b0, 0);

    // 3: oversize shift flushes; shift 26 lands on the MSB
    for (int i = 0; i < SL; i++) sbits[i] = 1'b1;
    start_job(40);
    feed(SL, 0, 20, 1'b1);
    expect_done("t3a");
    check("t3a_literal", 64'(bus.result), 64'd0);
    release_job(1'b0, 0);
    start_job(26);
    feed(SL, 0, 20, 1'b1);
    expect_done("t3b");
    check("t3b_literal", 64'(bus.result), 64'h8000_0000);
    release_job(1'b0, 0);

    // 4: 5 cycles of backpressure
    start_job(4);
    feed(SL, 0, 0, 1'b0);
    expect_done("t4");
    check("t4_literal", 64'(bus.result), 64'd512);
    hold(5);
    release_job(1'b0, 0);

    // 5: reset mid-stream aborts the job and clears outputs
    for (int i = 0; i < SL; i++) sbits[i] = 1'($urandom);
    start_job(2);
    feed(10, 0, 0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_busy",      64'(bus.busy),      64'd0);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_result",    64'(bus.result),    64'd0);
    check("t5_ones_cnt",  64'(bus.ones_cnt),  64'd0);
    for (int i = 0; i < SL; i++) sbits[i] = 1'b0;
    start_job(5);
    feed(SL, 0, 0, 1'b0);
    expect_done("t5z");
    release_job(1'b0, 0);

    // 6: back-to-back job started on the handshake cycle
    for (int i = 0; i < SL; i++) sbits[i] = 1'b1;
    start_job(2);
    feed(SL, 0, 0, 1'b0);
    expect_done("t6a");
    hold(1);
    release_job(1'b1, 1);
    for (int i = 0; i < SL; i++) sbits[i] = (i < 8);
    feed(SL, 0, 0, 1'b0);
    expect_done("t6b");
    check("t6_literal", 64'(bus.result), 64'd16);
    release_job(1'b0, 0);

    // Randomized jobs: density, shift, stalls, backpressure and chaining all vary
    chained = 1'b0;
    for (int j = 0; j < 25; j++) begin
      dens = int'($urandom_range(100));
      for (int i = 0; i < SL; i++) sbits[i] = (int'($urandom_range(99)) < dens);
      if (!chained) start_job(int'($urandom_range(40)));
      feed(SL, 0, int'($urandom_range(50)), 1'b1);
      expect_done("rnd");
      hold(int'($urandom_range(3)));
      nsh     = int'($urandom_range(40));
      chained = 1'($urandom);
      release_job(chained, nsh);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
